// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the two handshake channels of the instruction encoder.
//   Command channel (host/UART side -> encoder):
//     cmd_valid, cmd_ready, cmd_funct[6:0], cmd_operand[15:0],
//     cmd_channel[7:0], cmd_source[1:0], cmd_des
//   Instruction channel (encoder -> decoder):
//     instr[31:0], instr_valid, instr_ready
//   Modports:
//     master : the environment (command source and decoder stage)
//     slave  : the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_funct;
    logic [15:0] cmd_operand;
    logic [7:0]  cmd_channel;
    logic [1:0]  cmd_source;
    logic        cmd_des;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output cmd_valid, cmd_funct, cmd_operand, cmd_channel, cmd_source, cmd_des,
        input  cmd_ready,
        input  instr, instr_valid,
        output instr_ready
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_operand, cmd_channel, cmd_source, cmd_des,
        output cmd_ready,
        output instr, instr_valid,
        input  instr_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs field-level commands into 32-bit decoder words, buffers them in a
//   small FIFO and issues them to the decoder over valid/ready. Issue stalls
//   after an interrupt-wait instruction (funct 0x21) until int_done pulses.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active high
//   bus          instr_encoder_if.slave (command + instruction channels)
//   int_done     one-cycle pulse releasing an interrupt wait
//   err_illegal  sticky flag: an illegal funct (0x2D-0x7F) was dropped
//   busy         FIFO non-empty, instruction pending, or waiting on int_done
//   issue_cnt    (only with INSTR_ENC_ISSUE_CNT_EN) instruction handshakes,
//                16-bit wrapping
//
// Optional feature macro: INSTR_ENC_ISSUE_CNT_EN
//
// Storage model: the word shown on instr stays in the FIFO until its
// handshake, so the output register is a registered read of the FIFO head
// and cmd_ready counts the displayed word as occupied.
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus,
    input  logic            int_done,
    output logic            err_illegal,
    output logic            busy
`ifdef INSTR_ENC_ISSUE_CNT_EN
    ,
    output logic [15:0]     issue_cnt
`endif
);

    localparam logic [0:0] ST_ISSUE = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [6:0] FUNCT_INT_WAIT = 7'h21;

    // ------------------------------------------------------------------
    // Command packing (combinational, evaluated at FIFO write)
    // ------------------------------------------------------------------
    logic [31:0] packed_word;
    logic        legal;

    always_comb begin
        packed_word        = '0;
        packed_word[31:25] = bus.cmd_funct;
        legal              = 1'b1;
        case (bus.cmd_funct) inside
            [7'h00:7'h1B], 7'h20, [7'h23:7'h2A]: begin
                packed_word[22:7] = bus.cmd_operand;
            end
            7'h1C: begin
                packed_word[15]   = bus.cmd_des;
                packed_word[14:7] = bus.cmd_channel;
            end
            7'h1D, 7'h1E, 7'h2C: begin
                packed_word[24:17] = bus.cmd_channel;
                packed_word[16:15] = bus.cmd_source;
            end
            7'h1F, 7'h2B: begin
                packed_word[8:7] = bus.cmd_source;
            end
            7'h21: begin
                // interrupt wait carries no fields
            end
            7'h22: begin
                packed_word[14:7] = bus.cmd_channel;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers and flags
    // ------------------------------------------------------------------
    logic [31:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [AW:0]  rd_ptr_next;
    logic         full;
    logic         empty;
    logic         accept;
    logic         wr_en;

    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign accept = bus.cmd_valid && !full;
    // Illegal commands complete the handshake but never reach the FIFO.
    assign wr_en  = accept && legal;

    // ------------------------------------------------------------------
    // Output stage and issue control
    // ------------------------------------------------------------------
    logic [31:0] instr_reg;
    logic        instr_valid_reg;
    logic [0:0]  state_reg;
    logic [0:0]  state_next;
    logic        err_illegal_reg;
    logic        pop;
    logic        int_fire;
    logic        hold;
    logic        avail;
    logic        load;

    assign pop      = instr_valid_reg && bus.instr_ready;
    assign int_fire = pop && (instr_reg[31:25] == FUNCT_INT_WAIT);

    // hold covers the int-wait handshake cycle itself so the following word
    // is not prefetched, and drops in the int_done cycle so the next word
    // becomes valid one cycle after the release pulse.
    assign hold = ((state_reg == ST_WAIT) && !int_done) || int_fire;

    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
    // Another entry exists behind the one being retired this cycle.
    assign avail = (wr_ptr_reg != rd_ptr_next);
    assign load  = (!instr_valid_reg || pop) && avail && !hold;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ISSUE: if (int_fire) state_next = ST_WAIT;
            ST_WAIT:  if (int_done) state_next = ST_ISSUE;
            default:  state_next = ST_ISSUE;
        endcase
    end

    // FIFO storage: plain array, no reset, so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= packed_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            state_reg       <= ST_ISSUE;
            err_illegal_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            if (load) begin
                instr_reg       <= mem[rd_ptr_next[AW-1:0]];
                instr_valid_reg <= 1'b1;
            end else if (pop) begin
                instr_valid_reg <= 1'b0;
            end
            state_reg <= state_next;
            if (accept && !legal) begin
                err_illegal_reg <= 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_ISSUE_CNT_EN
    logic [15:0] issue_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_reg <= '0;
        end else if (pop) begin
            issue_cnt_reg <= issue_cnt_reg + 16'd1;
        end
    end

    assign issue_cnt = issue_cnt_reg;
`endif

    assign bus.cmd_ready   = !full;
    assign bus.instr       = instr_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign err_illegal     = err_illegal_reg;
    assign busy            = !empty || instr_valid_reg || (state_reg == ST_WAIT);

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Table-driven packing vectors, hand-written corner sequences (latency,
//   full FIFO, interrupt wait, illegal funct, reset mid-transfer) and a
//   randomized phase checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic int_done;
    logic err_illegal;
    logic busy;
`ifdef INSTR_ENC_ISSUE_CNT_EN
    logic [15:0] issue_cnt;
`endif

    instr_encoder_if bus_if();

    instr_encoder #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .int_done   (int_done),
        .err_illegal(err_illegal),
        .busy       (busy)
`ifdef INSTR_ENC_ISSUE_CNT_EN
        ,
        .issue_cnt  (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] exp_q[$];
    int          model_cnt;
    bit          model_wait;
    bit          model_err;
    int          model_issued;
    bit          prev_stall;
    logic [31:0] prev_instr;

    typedef struct {
        int unsigned funct;
        int unsigned operand;
        int unsigned channel;
        int unsigned source;
        int unsigned des;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_funct   = '0;
        bus_if.cmd_operand = '0;
        bus_if.cmd_channel = '0;
        bus_if.cmd_source  = '0;
        bus_if.cmd_des     = 1'b0;
        bus_if.instr_ready = 1'b0;
        int_done           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic send(input int unsigned f, input int unsigned op, input int unsigned ch,
                        input int unsigned src, input int unsigned des);
        int guard;
        guard = 0;
        bus_if.cmd_funct   = 7'(f);
        bus_if.cmd_operand = 16'(op);
        bus_if.cmd_channel = 8'(ch);
        bus_if.cmd_source  = 2'(src);
        bus_if.cmd_des     = 1'(des);
        bus_if.cmd_valid   = 1'b1;
        while (!bus_if.cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus_if.cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=0, expected 1 within 50 cycles");
        end
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k;
        k = 0;
        while (!bus_if.instr_valid && k < limit) begin
            tick();
            k++;
        end
        check(name, 32'(bus_if.instr_valid), 32'd1);
    endtask

    // Reference packing, straight from the field layout rules.
    function automatic logic [31:0] ref_pack(input int unsigned f, input int unsigned op,
                                             input int unsigned ch, input int unsigned src,
                                             input int unsigned des);
        int unsigned w;
        w = f * 32'h0200_0000;
        if (f <= 'h1B || f == 'h20 || (f >= 'h23 && f <= 'h2A)) w += op * 128;
        else if (f == 'h1C)                          w += des * 32768 + ch * 128;
        else if (f == 'h1D || f == 'h1E || f == 'h2C) w += ch * 131072 + src * 32768;
        else if (f == 'h1F || f == 'h2B)             w += src * 128;
        else if (f == 'h22)                          w += ch * 128;
        return w;
    endfunction

    // One randomized (or draining) cycle, checked against the model.
    task automatic rand_cycle(input bit drain);
        int unsigned r, f;
        logic [31:0] w;
        if (drain) begin
            bus_if.cmd_valid   = 1'b0;
            bus_if.instr_ready = 1'b1;
            int_done           = model_wait;
        end else begin
            r = $urandom_range(0, 99);
            if (r < 8)       f = 'h21;
            else if (r < 14) f = $urandom_range('h2D, 'h7F);
            else             f = $urandom_range(0, 'h2C);
            bus_if.cmd_valid   = ($urandom_range(0, 2) != 0);
            bus_if.cmd_funct   = 7'(f);
            bus_if.cmd_operand = 16'($urandom);
            bus_if.cmd_channel = 8'($urandom);
            bus_if.cmd_source  = 2'($urandom);
            bus_if.cmd_des     = 1'($urandom);
            bus_if.instr_ready = ($urandom_range(0, 3) != 0);
            int_done = model_wait ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
        end

        check("rand_cmd_ready", 32'(bus_if.cmd_ready), 32'(model_cnt < DEPTH));
        check("rand_busy", 32'(busy), 32'((model_cnt > 0) || model_wait));
        check("rand_err_illegal", 32'(err_illegal), 32'(model_err));
        if (model_wait) check("rand_valid_in_wait", 32'(bus_if.instr_valid), 32'd0);
        if (prev_stall) begin
            check("rand_stall_valid", 32'(bus_if.instr_valid), 32'd1);
            check("rand_stall_instr", bus_if.instr, prev_instr);
        end
`ifdef INSTR_ENC_ISSUE_CNT_EN
        check("rand_issue_cnt", 32'(issue_cnt), 32'(model_issued[15:0]));
`endif

        if (bus_if.cmd_valid && bus_if.cmd_ready) begin
            f = bus_if.cmd_funct;
            if (f <= 'h2C) begin
                exp_q.push_back(ref_pack(f, bus_if.cmd_operand, bus_if.cmd_channel,
                                         bus_if.cmd_source, bus_if.cmd_des));
                model_cnt++;
            end else begin
                model_err = 1'b1;
            end
        end
        if (bus_if.instr_valid && bus_if.instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_spurious_issue: got 0x%08h, expected no word", bus_if.instr);
            end else begin
                w = exp_q.pop_front();
                check("rand_issue_word", bus_if.instr, w);
                model_cnt--;
                model_issued++;
                if (w[31:25] == 7'h21) model_wait = 1'b1;
            end
        end else if (int_done && model_wait) begin
            model_wait = 1'b0;
        end
        prev_stall = bus_if.instr_valid && !bus_if.instr_ready;
        prev_instr = bus_if.instr;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{'h10, 'hABCD, 'h00, 0, 0, 32'h2055E680};
        vecs[1]  = '{'h1D, 'hFFFF, 'h3C, 1, 0, 32'h3A788000};
        vecs[2]  = '{'h1C, 'h1234, 'hA5, 2, 1, 32'h3800D280};
        vecs[3]  = '{'h22, 'h0000, 'hFF, 3, 1, 32'h44007F80};
        vecs[4]  = '{'h1F, 'hFFFF, 'hFF, 2, 1, 32'h3E000100};
        vecs[5]  = '{'h2B, 'h0000, 'h00, 3, 0, 32'h56000180};
        vecs[6]  = '{'h2C, 'h0000, 'h01, 2, 0, 32'h58030000};
        vecs[7]  = '{'h2A, 'h0001, 'h00, 0, 0, 32'h54000080};
        vecs[8]  = '{'h00, 'hFFFF, 'hFF, 3, 1, 32'h007FFF80};
        vecs[9]  = '{'h20, 'h8000, 'h00, 0, 0, 32'h40400000};
        vecs[10] = '{'h1E, 'h0000, 'h80, 0, 0, 32'h3D000000};
        vecs[11] = '{'h1B, 'h5555, 'h00, 0, 0, 32'h362AAA80};
        vecs[12] = '{'h23, 'h0F0F, 'hFF, 3, 1, 32'h46078780};

        idle_inputs();
        do_reset();

        // reset state
        check("reset_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("reset_instr_valid", 32'(bus_if.instr_valid), 32'd0);
        check("reset_instr", bus_if.instr, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err_illegal), 32'd0);

        // packing table
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].funct, vecs[i].operand, vecs[i].channel, vecs[i].source, vecs[i].des);
            wait_valid("vec_valid", 10);
            check("vec_instr", bus_if.instr, vecs[i].exp);
            $display("vec %0d funct=0x%02h instr=0x%08h expected=0x%08h",
                     i, vecs[i].funct, bus_if.instr, vecs[i].exp);
            bus_if.instr_ready = 1'b1;
            tick();
            bus_if.instr_ready = 1'b0;
            check("vec_consumed", 32'(bus_if.instr_valid), 32'd0);
        end

        // latency: accept -> instr_valid two clocks later
        send('h10, 'hABCD, 0, 0, 0);
        check("latency_1clk", 32'(bus_if.instr_valid), 32'd0);
        tick();
        check("latency_2clk", 32'(bus_if.instr_valid), 32'd1);
        bus_if.instr_ready = 1'b1;
        tick();
        bus_if.instr_ready = 1'b0;
        $display("seq latency done");

        // four commands with no consumer fill the queue
        for (int i = 1; i <= 4; i++) send(0, i, 0, 0, 0);
        check("full_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("full_instr", bus_if.instr, 32'h00000080);
        check("full_busy", 32'(busy), 32'd1);
        bus_if.instr_ready = 1'b1;
        tick();
        bus_if.instr_ready = 1'b0;
        check("full_after_issue_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("full_after_issue_instr", bus_if.instr, 32'h00000100);
        check("full_after_issue_valid", 32'(bus_if.instr_valid), 32'd1);
        bus_if.instr_ready = 1'b1;
        tick();
        check("full_drain_3", bus_if.instr, 32'h00000180);
        tick();
        check("full_drain_4", bus_if.instr, 32'h00000200);
        tick();
        check("full_drain_empty", 32'(bus_if.instr_valid), 32'd0);
        check("full_drain_busy", 32'(busy), 32'd0);
        $display("seq full-fifo done");

        // interrupt wait: second word withheld until int_done
        send('h21, 0, 0, 0, 0);
        send('h10, 'hABCD, 0, 0, 0);
        check("wait_first_word", bus_if.instr, 32'h42000000);
        int_done = 1'b1;            // coincident with the 0x21 handshake: ignored
        tick();
        int_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wait_withheld", 32'(bus_if.instr_valid), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            tick();
        end
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
        check("wait_release_valid", 32'(bus_if.instr_valid), 32'd1);
        check("wait_release_instr", bus_if.instr, 32'h2055E680);
        tick();
        check("wait_done_busy", 32'(busy), 32'd0);
        bus_if.instr_ready = 1'b0;
        $display("seq int-wait done");

        // illegal funct: dropped, sticky error until reset
        send('h50, 'h1234, 'h12, 1, 1);
        for (int i = 0; i < 4; i++) begin
            check("illegal_no_issue", 32'(bus_if.instr_valid), 32'd0);
            tick();
        end
        check("illegal_err", 32'(err_illegal), 32'd1);
        check("illegal_busy", 32'(busy), 32'd0);
        send('h7F, 0, 0, 0, 0);
        send('h2D, 0, 0, 0, 0);
        tick();
        check("illegal_boundary_no_issue", 32'(bus_if.instr_valid), 32'd0);
        do_reset();
        check("illegal_err_cleared", 32'(err_illegal), 32'd0);
        $display("seq illegal done");

        // reset with words queued and one on the output
        for (int i = 1; i <= 4; i++) send(0, i, 0, 0, 0);
        check("rst_pre_valid", 32'(bus_if.instr_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_valid", 32'(bus_if.instr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instr", bus_if.instr, 32'h0);
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        rst = 1'b0;
        tick();
        check("rst_stays_empty", 32'(bus_if.instr_valid), 32'd0);
        $display("seq reset done");

        // randomized phase
        do_reset();
        exp_q.delete();
        model_cnt    = 0;
        model_wait   = 1'b0;
        model_err    = 1'b0;
        model_issued = 0;
        prev_stall   = 1'b0;
        prev_instr   = '0;
        for (int c = 0; c < 1500; c++) rand_cycle(1'b0);
        for (int c = 0; c < 40; c++) rand_cycle(1'b1);
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("random phase: %0d words issued", model_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
